// File: rtl/load_wb.sv
// load_wb: RV32I load unit. Accepts one load at a time from the execute stage,
// issues a word-aligned read to data memory, extracts and extends the
// addressed byte/halfword/word, and writes it back to the register file.
// A memory that never answers is abandoned after TIMEOUT_CYCLES WAIT cycles.
// Optional build macro LOAD_WB_MISALIGN_CHECK_EN rejects misaligned lh/lhu/lw
// with an err pulse instead of issuing them.
module load_wb #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        w_en,
    output logic [4:0]  rd_id_o,
    output logic [31:0] rd_write_data_o,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Last counter value before the timeout fires; the counter starts at 0 on
    // entry to WAIT, so WAIT lasts TIMEOUT_CYCLES cycles when nothing answers.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;

    logic accept;
    logic req_bad;
    logic req_misalign;
    logic rsp_take;
    logic timeout;

    function automatic logic funct3_illegal(input logic [2:0] f3);
        case (f3)
            3'b011, 3'b110, 3'b111: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

`ifdef LOAD_WB_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            3'b001, 3'b101: return lane[0];
            3'b010:         return |lane;
            default:        return 1'b0;
        endcase
    endfunction

    assign req_misalign = misaligned(req_funct3, req_addr[1:0]);
`else
    // Without the check, halfwords use addr[1] only and words use the whole
    // aligned word, so the low bits never make a request illegal.
    assign req_misalign = 1'b0;
`endif

    // Byte/halfword selection with sign or zero extension per load type.
    function automatic logic [31:0] extract(input logic [2:0]  f3,
                                            input logic [1:0]  lane,
                                            input logic [31:0] word);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] r_s;
        logic        [31:0] res;
        b_s = word[{lane, 3'b000} +: 8];
        h_s = lane[1] ? word[31:16] : word[15:0];
        r_s = '0;
        res = '0;
        case (f3)
            3'b000: begin r_s = b_s; res = r_s; end
            3'b001: begin r_s = h_s; res = r_s; end
            3'b010: res = word;
            3'b100: res = {24'd0, b_s};
            3'b101: res = {16'd0, h_s};
            default: res = '0;
        endcase
        return res;
    endfunction

    assign accept   = req_valid & req_ready;
    assign req_bad  = funct3_illegal(req_funct3) | req_misalign;
    assign rsp_take = (state == S_WAIT) & mem_rsp_valid;
    assign timeout  = (state == S_WAIT) & ~mem_rsp_valid & (cnt == TO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a response always wins over a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid && !req_bad) state_nxt = S_REQ;
            S_REQ:  if (mem_req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_rsp_valid)  state_nxt = S_WB;
                else if (timeout)   state_nxt = S_IDLE;
            end
            S_WB:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control outputs decoded from state; rst masks strobes within its own cycle.
    always_comb begin
        req_ready     = (state == S_IDLE) & ~rst;
        mem_req_valid = (state == S_REQ) & ~rst;
        w_en          = (state == S_WB) & (rd_q != 5'd0) & ~rst;
        busy          = (state != S_IDLE);
    end

    // Request capture at accept and write-back data capture at response.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr        <= '0;
            f3_q            <= '0;
            lane_q          <= '0;
            rd_q            <= '0;
            rd_id_o         <= '0;
            rd_write_data_o <= '0;
        end else begin
            if (accept) begin
                mem_addr <= {req_addr[31:2], 2'b00};
                f3_q     <= req_funct3;
                lane_q   <= req_addr[1:0];
                rd_q     <= req_rd;
            end
            if (rsp_take) begin
                rd_id_o         <= rd_q;
                rd_write_data_o <= extract(f3_q, lane_q, mem_rsp_data);
            end
        end
    end

    // WAIT-cycle counter, cleared on the request handshake.
    always_ff @(posedge clk) begin
        if (rst)                                     cnt <= '0;
        else if (state == S_REQ && mem_req_ready)    cnt <= '0;
        else if (state == S_WAIT)                    cnt <= cnt + 16'd1;
    end

    // One-cycle error pulse for rejected requests and memory timeouts.
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= (accept & req_bad) | timeout;
    end

endmodule

// File: tb/tb_load_wb.sv
// tb_load_wb: directed and randomized loads against a behavioural model of
// the load unit, with a short memory timeout to exercise the abort path.
module tb_load_wb;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        w_en;
    logic [4:0]  rd_id_o;
    logic [31:0] rd_write_data_o;
    logic        busy;
    logic        err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    load_wb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .w_en(w_en), .rd_id_o(rd_id_o),
        .rd_write_data_o(rd_write_data_o), .busy(busy), .err(err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        nvec++;
        assert (obs === expd) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Value the register file should receive for a load of this type.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] word);
        int unsigned b, h;
        b = (word >> (8 * addr[1:0])) & 32'hFF;
        h = (word >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b - 256 : b;
            3'd1: return (h >= 32768) ? h - 65536 : h;
            3'd2: return word;
            3'd4: return b;
            3'd5: return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_illegal(input logic [2:0] f3, input logic [31:0] addr);
        bit bad, mis;
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        mis = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && (addr % 4 != 0));
`ifndef LOAD_WB_MISALIGN_CHECK_EN
        mis = 1'b0;
`endif
        return bad || mis;
    endfunction

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] word, input logic [31:0] expd,
                           input int rdy_dly, input int rsp_dly);
        bit bad;
        bad = is_illegal(f3, addr);
        chk("idle_ready", req_ready, 1);
        req_valid = 1; req_addr = addr; req_funct3 = f3; req_rd = rd;
        tick();
        req_valid = 0; req_addr = $urandom; req_funct3 = 3'($urandom); req_rd = 5'($urandom);
        if (bad) begin
            chk("bad_err", err, 1);
            chk("bad_memreq", mem_req_valid, 0);
            chk("bad_busy", busy, 0);
            tick();
            chk("bad_err_clr", err, 0);
            chk("bad_memreq2", mem_req_valid, 0);
            return;
        end
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("req_err", err, 0);
        for (int i = 0; i < rdy_dly; i++) begin
            mem_rsp_valid = 1; mem_rsp_data = $urandom;
            tick();
            chk("req_hold_valid", mem_req_valid, 1);
            chk("req_hold_addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("req_not_ready", req_ready, 0);
        end
        mem_rsp_valid = 0;
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        chk("wait_memreq", mem_req_valid, 0);
        for (int i = 0; i < rsp_dly; i++) begin
            tick();
            chk("wait_wen", w_en, 0);
            chk("wait_err", err, 0);
        end
        mem_rsp_valid = 1; mem_rsp_data = word;
        tick();
        mem_rsp_valid = 0; mem_rsp_data = $urandom;
        chk("wb_wen", w_en, (rd != 5'd0));
        chk("wb_err", err, 0);
        if (rd != 5'd0) begin
            chk("wb_rd", rd_id_o, rd);
            chk("wb_data", rd_write_data_o, expd);
        end
        tick();
        chk("post_wen", w_en, 0);
        chk("post_busy", busy, 0);
        chk("post_ready", req_ready, 1);
        if (rd != 5'd0) chk("post_data_hold", rd_write_data_o, expd);
    endtask

    task automatic do_timeout(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
        req_valid = 1; req_addr = addr; req_funct3 = f3; req_rd = rd;
        tick();
        req_valid = 0;
        chk("to_memreq", mem_req_valid, 1);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        for (int i = 0; i < TO; i++) begin
            chk("to_wait_err", err, 0);
            chk("to_wait_busy", busy, 1);
            chk("to_wait_wen", w_en, 0);
            tick();
        end
        chk("to_err", err, 1);
        chk("to_idle", busy, 0);
        chk("to_wen", w_en, 0);
        mem_rsp_valid = 1; mem_rsp_data = $urandom;
        tick();
        mem_rsp_valid = 0;
        chk("to_err_clr", err, 0);
        chk("late_rsp_wen", w_en, 0);
        chk("late_rsp_busy", busy, 0);
        tick();
        chk("late_rsp_wen2", w_en, 0);
    endtask

    task automatic do_reset_mid();
        chk("rm_ready", req_ready, 1);
        req_valid = 1; req_addr = 32'h0000_0700; req_funct3 = 3'd2; req_rd = 5'd4;
        tick();
        req_valid = 0;
        chk("rm_memreq", mem_req_valid, 1);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        chk("rm_busy", busy, 1);
        rst = 1;
        tick();
        chk("rm_rst_ready", req_ready, 0);
        chk("rm_rst_busy", busy, 0);
        chk("rm_rst_wen", w_en, 0);
        chk("rm_rst_err", err, 0);
        chk("rm_rst_rd", rd_id_o, 0);
        chk("rm_rst_data", rd_write_data_o, 0);
        chk("rm_rst_addr", mem_addr, 0);
        rst = 0;
        mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D;
        tick();
        mem_rsp_valid = 0;
        chk("rm_after_ready", req_ready, 1);
        chk("rm_after_wen", w_en, 0);
        chk("rm_after_err", err, 0);
        tick();
        chk("rm_after_wen2", w_en, 0);
        chk("rm_after_err2", err, 0);
    endtask

    initial begin
        logic [31:0] a, w;
        logic [2:0]  f;
        logic [4:0]  r;

        rst = 1; req_valid = 0; req_addr = 0; req_funct3 = 0; req_rd = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        tick();
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wen", w_en, 0);
        chk("rst_memreq", mem_req_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_rd", rd_id_o, 0);
        chk("rst_data", rd_write_data_o, 0);
        chk("rst_addr", mem_addr, 0);
        rst = 0;
        tick();
        chk("rel_ready", req_ready, 1);

        do_load(32'h0000_1003, 3'd0, 5'd5, 32'h80FF_1234, 32'hFFFF_FF80, 0, 0);
        do_load(32'h0000_2002, 3'd5, 5'd7, 32'h8001_ABCD, 32'h0000_8001, 0, 0);
        do_load(32'h0000_2002, 3'd1, 5'd7, 32'h8001_ABCD, 32'hFFFF_8001, 0, 0);
        do_load(32'h0000_3000, 3'd2, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
        do_load(32'h0000_1002, 3'd2, 5'd9, 32'h1122_3344, 32'h1122_3344, 0, 0);
        do_load(32'h0000_1001, 3'd4, 5'd10, 32'h1122_3344, 32'h0000_0033, 1, 2);
        do_load(32'h0000_0040, 3'd3, 5'd1, 32'h0, 32'h0, 0, 0);
        do_load(32'h0000_0040, 3'd6, 5'd1, 32'h0, 32'h0, 0, 0);
        do_load(32'h0000_0040, 3'd7, 5'd1, 32'h0, 32'h0, 0, 0);

        do_timeout(32'h0000_0500, 3'd4, 5'd3);
        do_load(32'h0000_0504, 3'd2, 5'd3, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, TO - 1);
        do_reset_mid();

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            w = $urandom;
            f = 3'($urandom_range(0, 7));
            r = 5'($urandom);
            do_load(a, f, r, w, model(f, a, w), $urandom_range(0, 2), $urandom_range(0, TO - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/load_wb.md
LOAD_WB -- requirements
Module: load_wb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: WAIT-state cycles without a memory response before abort; legal range 1..65535.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst  input  1  Reset is synchronous and active-high.
REQ-004 req_valid  input  1  Load request from execute stage.
REQ-005 req_ready  output  1  Unit can accept a request.
REQ-006 req_addr  input  32  Byte address of the load.
REQ-007 req_funct3  input  3  RV32I load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-008 req_rd  input  5  Destination register index.
REQ-009 mem_req_valid  output  1  Read request to data memory.
REQ-010 mem_req_ready  input  1  Memory accepts the read request.
REQ-011 mem_addr  output  32  Word-aligned read address, {addr[31:2],2'b00}.
REQ-012 mem_rsp_valid  input  1  Read data valid.
REQ-013 mem_rsp_data  input  32  Read data word, little-endian.
REQ-014 w_en  output  1  Regfile write enable.
REQ-015 rd_id_o  output  5  Regfile write index.
REQ-016 rd_write_data_o  output  32  Regfile write data.
REQ-017 busy  output  1  High in any state other than IDLE.
REQ-018 err  output  1  One-cycle pulse: illegal funct3, misalignment or timeout.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, WB; req_ready = 1 only in IDLE and not during rst.
REQ-020 IDLE: on req_valid & req_ready, capture addr/funct3/rd; a legal request goes to REQ, an illegal funct3 (011, 110, 111) pulses err next cycle and stays IDLE.
REQ-021 REQ: mem_req_valid = 1 with mem_addr held stable; on mem_req_ready, go to WAIT and clear the timeout counter.
REQ-022 WAIT: on mem_rsp_valid, capture the extracted data and go to WB; mem_rsp_valid in any other state SHALL be ignored.
REQ-023 WAIT timeout: if the counter reaches TIMEOUT_CYCLES without a response, pulse err, return to IDLE, no write.
REQ-024 WB: w_en = 1 for exactly one cycle with rd_id_o/rd_write_data_o valid, then IDLE; rd = 0 SHALL suppress w_en and still return to IDLE.
REQ-025 Extraction: lane = addr[1:0]; lb/lbu use byte data[8*lane+7:8*lane]; lh/lhu use halfword addr[1] (bits 15:0 or 31:16); lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through.
REQ-026 Minimum latency: accept at cycle T, mem_req_valid at T+1, response sampled at T+2, w_en at T+3; a new request is accepted no earlier than T+4.
REQ-027 w_en, mem_req_valid and err SHALL be 0 whenever not driven by the rules above; rd_id_o/rd_write_data_o hold their last value.

Reset
REQ-028 rst SHALL force IDLE, counter 0, w_en/mem_req_valid/err/busy = 0, rd_id_o = 0, rd_write_data_o = 0, mem_addr = 0.
REQ-029 rst asserted mid-operation SHALL abort the operation with no w_en and no err; req_ready = 1 the cycle after rst deasserts.

Configuration
REQ-030 Macro LOAD_WB_MISALIGN_CHECK_EN defined: lh/lhu with addr[0] = 1 or lw with addr[1:0] != 0 SHALL pulse err at accept+1, issue no memory request, and stay IDLE.
REQ-031 Macro undefined: the low address bits are ignored for alignment (halfword uses addr[1] only, lw uses the whole word) and the load completes normally.

Verification
REQ-032 lb addr 0x1003, rd 5, memory returns 0x80FF_1234 -> w_en at T+3, rd_id_o 5, data 0xFFFF_FF80.
REQ-033 lhu addr 0x2002, rd 7, data 0x8001_ABCD -> data 0x0000_8001; lh at the same address -> 0xFFFF_8001.
REQ-034 lw rd 0 -> memory transaction occurs, w_en never asserted, busy low at T+4.
REQ-035 TIMEOUT_CYCLES = 4, no response -> err pulse after 4 WAIT cycles, IDLE, no w_en; a late mem_rsp_valid is ignored.
REQ-036 With the macro defined, lw addr 0x1002 -> err at T+1, mem_req_valid never high; without the macro, word 0x1000 is written.
REQ-037 rst in WAIT, then mem_rsp_valid -> no w_en, no err, req_ready = 1 the cycle after rst deasserts.
